pll_cfg_writer: RTL and testbench

//  Avalon-MM master that reprograms a fractional altera_pll through its altera_pll_reconfig management port.

---
 rtl/pll_cfg_writer.sv | 145 ++++++++++++++
 tb/tb_pll_cfg_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_cfg_writer.sv
// Avalon-MM master that reprograms a fractional altera_pll through altera_pll_reconfig:
// writes MODE, N, M, C and K, then START, then waits for the PLL to re-lock or time out.
module pll_cfg_writer #(
  parameter int LOCK_TO_W = 20,
  parameter int SETTLE    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [15:0] cfg_n,
  input  logic [15:0] cfg_m,
  input  logic [15:0] cfg_c,
  input  logic [4:0]  cfg_c_sel,
  input  logic [31:0] cfg_k,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  // Error is registered on the cycle the counter would step to all-ones.
  localparam logic [LOCK_TO_W-1:0] LOCK_LAST = {{(LOCK_TO_W-1){1'b1}}, 1'b0};

  typedef enum logic [3:0] {
    S_IDLE, S_W_MODE, S_W_N, S_W_M, S_W_C, S_W_K, S_W_START, S_SETTLE, S_WAIT_LOCK
  } state_t;

  state_t                r_state;
  logic [15:0]           r_n, r_m, r_c;
  logic [4:0]            r_c_sel;
  logic [31:0]           r_k;
  logic [5:0]            r_addr;
  logic [31:0]           r_data;
  logic                  r_write, r_busy, r_done, r_error;
  logic [SW-1:0]         r_settle_cnt;
  logic [LOCK_TO_W-1:0]  r_lock_cnt;
  logic                  w_wr_done;

  assign w_wr_done      = r_write & ~mgmt_waitrequest;
  assign mgmt_address   = r_addr;
  assign mgmt_writedata = r_data;
  assign mgmt_write     = r_write;
  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign cfg_ready      = ~r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_m          <= '0;
      r_c          <= '0;
      r_c_sel      <= '0;
      r_k          <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_write      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_settle_cnt <= '0;
      r_lock_cnt   <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // busy is still high during the done/error cycle, which blocks acceptance there
          r_busy <= 1'b0;
          if (cfg_valid && !r_busy) begin
            r_n     <= cfg_n;
            r_m     <= cfg_m;
            r_c     <= cfg_c;
            r_c_sel <= cfg_c_sel;
            r_k     <= cfg_k;
            r_busy  <= 1'b1;
            r_write <= 1'b1;
            r_addr  <= 6'h00;
            r_data  <= 32'h0;
            r_state <= S_W_MODE;
          end
        end
        S_W_MODE: if (w_wr_done) begin
          r_addr  <= 6'h03;
          r_data  <= {16'h0, r_n};
          r_state <= S_W_N;
        end
        S_W_N: if (w_wr_done) begin
          r_addr  <= 6'h04;
          r_data  <= {16'h0, r_m};
          r_state <= S_W_M;
        end
        S_W_M: if (w_wr_done) begin
          r_addr  <= 6'h05;
          r_data  <= {11'h0, r_c_sel, r_c};
          r_state <= S_W_C;
        end
        S_W_C: if (w_wr_done) begin
          r_addr  <= 6'h07;
          r_data  <= r_k;
          r_state <= S_W_K;
        end
        S_W_K: if (w_wr_done) begin
          r_addr  <= 6'h02;
          r_data  <= 32'h1;
          r_state <= S_W_START;
        end
        S_W_START: if (w_wr_done) begin
          r_write      <= 1'b0;
          r_settle_cnt <= '0;
          r_state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            r_lock_cnt <= '0;
            r_state    <= S_WAIT_LOCK;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (pll_locked) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_lock_cnt == LOCK_LAST) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_cfg_writer.sv
// Self-checking bench for pll_cfg_writer: table vectors, random requests against a
// transaction-level model, and a mid-sequence reset sequence.
module tb_pll_cfg_writer;
  localparam int LTW = 6;
  localparam int ST  = 16;
  localparam int LOCK_ALL = (1 << LTW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [15:0] cfg_n, cfg_m, cfg_c;
  logic [4:0]  cfg_c_sel;
  logic [31:0] cfg_k;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;
  logic        pll_locked;
  logic        busy, done, error;

  pll_cfg_writer #(.LOCK_TO_W(LTW), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c(cfg_c), .cfg_c_sel(cfg_c_sel), .cfg_k(cfg_k),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] n, m, c;
    logic [4:0]  csel;
    logic [31:0] k;
  } req_t;

  // wmode: 0 no stalls, 1 random stalls, 2 three stalls on N and START
  // lock_at: first cycle (0 = first cycle after START completes) with locked=1; <0 = always locked
  typedef struct {
    req_t req;
    int   wmode;
    int   lock_at;
    bit   extra;
    bit   exp_err;
    int   exp_j;
    int   exp_start;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [37:0] exp_write(input int idx, input req_t r);
    case (idx)
      0: return {6'h00, 32'h0};
      1: return {6'h03, 16'h0, r.n};
      2: return {6'h04, 16'h0, r.m};
      3: return {6'h05, 11'h0, r.csel, r.c};
      4: return {6'h07, r.k};
      default: return {6'h02, 32'h1};
    endcase
  endfunction

  // Cycle index (after START completes) at which the done/error pulse is visible.
  function automatic int exp_pulse(input int lock_at, output bit is_err);
    int k;
    k = (lock_at > ST) ? lock_at - ST : 0;
    if (k <= LOCK_ALL - 1) begin
      is_err = 1'b0;
      return ST + k + 1;
    end
    is_err = 1'b1;
    return ST + LOCK_ALL;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.n = 16'($urandom); r.m = 16'($urandom); r.c = 16'($urandom);
    r.csel = 5'($urandom); r.k = $urandom;
    return r;
  endfunction

  task automatic run_txn(input req_t r, input int wmode, input int lock_at, input bit extra,
                         output bit got_err, output int got_j, output int start_cyc);
    int nwr = 0, nwait = 0, hold = 0, j = -1;
    bit started = 0, prev_stall = 0, seen = 0, w;
    logic [5:0] paddr;
    logic [31:0] pdata;
    got_err = 0; got_j = -1; start_cyc = -1;
    @(negedge clk);
    chk("ready_before_req", cfg_ready, 1);
    cfg_n = r.n; cfg_m = r.m; cfg_c = r.c; cfg_c_sel = r.csel; cfg_k = r.k;
    cfg_valid = 1'b1;
    pll_locked = (lock_at < 0);
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (extra) begin
        cfg_valid = 1'b1;
        cfg_n = 16'($urandom); cfg_m = 16'($urandom); cfg_c = 16'($urandom);
        cfg_c_sel = 5'($urandom); cfg_k = $urandom;
      end else cfg_valid = 1'b0;
      if (started) j++;
      pll_locked = (lock_at < 0) || (started && j >= lock_at);
      if (done || error) begin
        chk("pulse_after_start", started, 1);
        chk("done_error_exclusive", done & error, 0);
        chk("busy_in_pulse", busy, 1);
        got_err = error; got_j = j; seen = 1;
        break;
      end
      if (prev_stall) begin
        chk("stall_addr_stable", mgmt_address, paddr);
        chk("stall_data_stable", mgmt_writedata, pdata);
      end
      if (mgmt_write) begin
        case (wmode)
          1: w = ($urandom_range(0, 2) == 0);
          2: w = (mgmt_address == 6'h03 || mgmt_address == 6'h02) && hold < 3;
          default: w = 1'b0;
        endcase
        mgmt_waitrequest = w;
        if (w) begin
          hold++; nwait++;
        end else begin
          hold = 0;
          if (nwr < 6) chk($sformatf("write%0d", nwr), {mgmt_address, mgmt_writedata}, exp_write(nwr, r));
          nwr++;
          if (mgmt_address == 6'h02 && !started) begin
            started = 1; start_cyc = cyc; j = -1;
          end
        end
        prev_stall = w; paddr = mgmt_address; pdata = mgmt_writedata;
      end else begin
        mgmt_waitrequest = 1'b0;
        prev_stall = 0;
      end
      @(negedge clk);
    end
    if (!seen) chk("pulse_timeout", 0, 1);
    chk("write_count", nwr, 6);
    chk("start_cycle_vs_stalls", start_cyc, 5 + nwait);
    cfg_valid = 1'b0; pll_locked = 1'b0; mgmt_waitrequest = 1'b0;
    @(negedge clk);
    chk("pulse_one_cycle", {done, error}, 2'b00);
    chk("busy_after_pulse", busy, 0);
    chk("ready_after_pulse", cfg_ready, 1);
  endtask

  vec_t tbl[7];

  initial begin
    bit ge, ee;
    int gj, gs, ej;
    bit found;
    req_t r;

    tbl[0] = '{'{16'h0404, 16'h0A0A, 16'h0303, 5'd2, 32'h8000_0000}, 0, 40, 1'b0, 1'b0, 41, 5};
    tbl[1] = '{'{16'h0404, 16'h0A0A, 16'h0303, 5'd2, 32'h8000_0000}, 2, 40, 1'b0, 1'b0, 41, 11};
    tbl[2] = '{'{16'h1111, 16'h2222, 16'h3333, 5'd31, 32'hDEAD_BEEF}, 0, -1, 1'b0, 1'b0, 17, 5};
    tbl[3] = '{'{16'h0102, 16'h0304, 16'h0506, 5'd7, 32'h1234_5678}, 0, 1000, 1'b0, 1'b1, 79, 5};
    tbl[4] = '{'{16'hA5A5, 16'h5A5A, 16'hFFFF, 5'd0, 32'h0000_0001}, 0, 20, 1'b1, 1'b0, 21, 5};
    tbl[5] = '{'{16'h0001, 16'h0002, 16'h0003, 5'd4, 32'h0000_0005}, 0, 78, 1'b0, 1'b0, 79, 5};
    tbl[6] = '{'{16'h0007, 16'h0008, 16'h0009, 5'd10, 32'hFFFF_FFFF}, 0, 79, 1'b0, 1'b1, 79, 5};

    rst = 1'b1; cfg_valid = 1'b0; cfg_n = '0; cfg_m = '0; cfg_c = '0; cfg_c_sel = '0; cfg_k = '0;
    mgmt_waitrequest = 1'b0; pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_write", mgmt_write, 0);
    chk("rst_addr", mgmt_address, 0);
    chk("rst_data", mgmt_writedata, 0);
    chk("rst_flags", {busy, done, error}, 3'b000);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_txn(tbl[i].req, tbl[i].wmode, tbl[i].lock_at, tbl[i].extra, ge, gj, gs);
      chk($sformatf("vec%0d_is_error", i), ge, tbl[i].exp_err);
      chk($sformatf("vec%0d_pulse_cycle", i), gj, tbl[i].exp_j);
      chk($sformatf("vec%0d_start_cycle", i), gs, tbl[i].exp_start);
    end

    for (int t = 0; t < 20; t++) begin
      int la;
      bit ex;
      r = rand_req();
      la = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 90));
      ex = 1'($urandom);
      run_txn(r, 1, la, ex, ge, gj, gs);
      ej = exp_pulse(la, ee);
      chk($sformatf("rand%0d_is_error", t), ge, ee);
      chk($sformatf("rand%0d_pulse_cycle", t), gj, ej);
    end

    // reset while the M write is stalled
    @(negedge clk);
    r = rand_req();
    cfg_n = r.n; cfg_m = r.m; cfg_c = r.c; cfg_c_sel = r.csel; cfg_k = r.k;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (mgmt_write && mgmt_address == 6'h04) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_seq_reached_m", found, 1);
    mgmt_waitrequest = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_write", mgmt_write, 0);
    chk("midrst_addr_data", {mgmt_address, mgmt_writedata}, 38'h0);
    chk("midrst_busy_ready", {busy, cfg_ready}, 2'b01);
    @(negedge clk);
    rst = 1'b0; mgmt_waitrequest = 1'b0;
    r = rand_req();
    run_txn(r, 0, 30, 1'b0, ge, gj, gs);
    ej = exp_pulse(30, ee);
    chk("after_rst_is_error", ge, ee);
    chk("after_rst_pulse_cycle", gj, ej);
    chk("after_rst_start_cycle", gs, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
